// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register indices, default widths, operand-fetch state encoding.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package cpu_pkg;

    localparam int DATA_W = 32;
    localparam int REG_AW = 4;

    localparam logic [REG_AW-1:0] REG_PC = 4'd15;
    localparam logic [REG_AW-1:0] REG_LR = 4'd14;
    localparam logic [REG_AW-1:0] REG_SP = 4'd13;

    typedef enum logic {
        RUN        = 1'b0,
        LOAD_STALL = 1'b1
    } stage_state_t;

endpackage

// File: rtl/operand_forward_mux.sv
// Resolves one source operand: PC+8 for R15, else EX forward, else WB forward, else regfile.
// Latency: purely combinational.
// Backpressure: none; the caller decides when the result is captured.
module operand_forward_mux
    import cpu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int REG_AW_P = REG_AW
) (
    input  logic [REG_AW_P-1:0] idx,
    input  logic [DATA_W_P-1:0] rf_data,
    input  logic [DATA_W_P-1:0] pc_plus8,
    input  logic                ex_writes,
    input  logic                ex_is_load,
    input  logic [REG_AW_P-1:0] ex_rd,
    input  logic [DATA_W_P-1:0] ex_result,
    input  logic                wb_writes,
    input  logic [REG_AW_P-1:0] wb_rd,
    input  logic [DATA_W_P-1:0] wb_data,
    output logic [DATA_W_P-1:0] data
);

    // Priority select; R15 is checked first so it can never be forwarded.
    // A load in EX has no data yet, so it is skipped here (the stage stalls instead).
    always_comb begin
        data = rf_data;
        if (idx == REG_AW_P'(REG_PC)) begin
            data = pc_plus8;
        end else if (ex_writes && !ex_is_load && (ex_rd == idx)) begin
            data = ex_result;
        end else if (wb_writes && (wb_rd == idx)) begin
            // Regfile commits at the edge, so same-cycle WB data is not in rf_data yet.
            data = wb_data;
        end
    end

endmodule

// File: rtl/operand_fetch_stage.sv
// Decode-to-execute stage: reads regfile, forwards EX/WB results, inserts load-use bubbles.
// Latency: 1 cycle from in_valid&&in_ready to out_valid; 1 instr/cycle without hazards.
// Backpressure: out_ready=0 holds all outputs and deasserts in_ready; flush kills both sides.
module operand_fetch_stage
    import cpu_pkg::*;
#(
    parameter int DATA_W_P = DATA_W,
    parameter int REG_AW_P = REG_AW,
    parameter int CTRL_W   = 16,
    parameter int CNT_W    = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [REG_AW_P-1:0] in_rn,
    input  logic [REG_AW_P-1:0] in_rm,
    input  logic [REG_AW_P-1:0] in_rd,
    input  logic                in_uses_rn,
    input  logic                in_uses_rm,
    input  logic                in_writes_rd,
    input  logic                in_is_load,
    input  logic [DATA_W_P-1:0] in_pc_plus8,
    input  logic [CTRL_W-1:0]   in_ctrl,
    output logic [REG_AW_P-1:0] rf_readReg1,
    output logic [REG_AW_P-1:0] rf_readReg2,
    input  logic [DATA_W_P-1:0] rf_readData1,
    input  logic [DATA_W_P-1:0] rf_readData2,
    input  logic                ex_writes,
    input  logic                ex_is_load,
    input  logic [REG_AW_P-1:0] ex_rd,
    input  logic [DATA_W_P-1:0] ex_result,
    input  logic                wb_writes,
    input  logic [REG_AW_P-1:0] wb_rd,
    input  logic [DATA_W_P-1:0] wb_data,
    input  logic                flush,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [DATA_W_P-1:0] out_opA,
    output logic [DATA_W_P-1:0] out_opB,
    output logic [REG_AW_P-1:0] out_rd,
    output logic                out_writes_rd,
    output logic                out_is_load,
    output logic [CTRL_W-1:0]   out_ctrl,
    output logic [CNT_W-1:0]    stall_cnt,
    output logic [CNT_W-1:0]    bubble_cnt
);

    logic [DATA_W_P-1:0] op_a;
    logic [DATA_W_P-1:0] op_b;
    logic                hazard;
    logic                advance;
    logic                bubble_inc;
    stage_state_t        state;
    stage_state_t        state_next;

    assign rf_readReg1 = in_rn;
    assign rf_readReg2 = in_rm;

    operand_forward_mux #(.DATA_W_P(DATA_W_P), .REG_AW_P(REG_AW_P)) u_fwd_rn (
        .idx        (in_rn),
        .rf_data    (rf_readData1),
        .pc_plus8   (in_pc_plus8),
        .ex_writes  (ex_writes),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .wb_writes  (wb_writes),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .data       (op_a)
    );

    operand_forward_mux #(.DATA_W_P(DATA_W_P), .REG_AW_P(REG_AW_P)) u_fwd_rm (
        .idx        (in_rm),
        .rf_data    (rf_readData2),
        .pc_plus8   (in_pc_plus8),
        .ex_writes  (ex_writes),
        .ex_is_load (ex_is_load),
        .ex_rd      (ex_rd),
        .ex_result  (ex_result),
        .wb_writes  (wb_writes),
        .wb_rd      (wb_rd),
        .wb_data    (wb_data),
        .data       (op_b)
    );

    // Load-use hazard: only sources that are actually read can stall.
    assign hazard = in_valid && ex_writes && ex_is_load &&
                    ((in_uses_rn && (ex_rd == in_rn)) || (in_uses_rm && (ex_rd == in_rm)));
    assign advance  = !out_valid || out_ready;
    assign in_ready = advance && !hazard && !flush;

    // Stall state register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    // Next state and bubble accounting; consecutive load-use hazards stay in LOAD_STALL.
    always_comb begin
        state_next = state;
        bubble_inc = 1'b0;
        case (state)
            RUN: begin
                if (!flush && advance && hazard) begin
                    state_next = LOAD_STALL;
                    bubble_inc = 1'b1;
                end
            end
            LOAD_STALL: begin
                if (advance) begin
                    if (!flush && hazard) begin
                        bubble_inc = 1'b1;
                    end else begin
                        state_next = RUN;
                    end
                end
            end
            default: state_next = RUN;
        endcase
    end

    // Output register and saturating counters; operands are resolved only at capture.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid     <= 1'b0;
            out_opA       <= '0;
            out_opB       <= '0;
            out_rd        <= '0;
            out_writes_rd <= 1'b0;
            out_is_load   <= 1'b0;
            out_ctrl      <= '0;
            stall_cnt     <= '0;
            bubble_cnt    <= '0;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (advance && hazard) begin
            out_valid <= 1'b0;
            if (bubble_inc && (bubble_cnt != '1)) begin
                bubble_cnt <= bubble_cnt + CNT_W'(1);
            end
        end else if (advance && in_valid) begin
            out_valid     <= 1'b1;
            out_opA       <= op_a;
            out_opB       <= op_b;
            out_rd        <= in_rd;
            out_writes_rd <= in_writes_rd;
            out_is_load   <= in_is_load;
            out_ctrl      <= in_ctrl;
        end else if (advance) begin
            out_valid <= 1'b0;
        end else if (in_valid && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_operand_fetch_stage.sv
// Directed bench for operand_fetch_stage with a scoreboard of expected captured operands.
// Latency: checks 1-cycle capture; scoreboard pops on each out_valid&&out_ready.
// Backpressure: exercises out_ready=0 holds, load-use bubbles, flush and mid-stall reset.
module tb_operand_fetch_stage;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  in_rn, in_rm, in_rd;
    logic        in_uses_rn, in_uses_rm, in_writes_rd, in_is_load;
    logic [31:0] in_pc_plus8;
    logic [15:0] in_ctrl;
    logic [3:0]  rf_readReg1, rf_readReg2;
    logic [31:0] rf_readData1, rf_readData2;
    logic        ex_writes, ex_is_load;
    logic [3:0]  ex_rd;
    logic [31:0] ex_result;
    logic        wb_writes;
    logic [3:0]  wb_rd;
    logic [31:0] wb_data;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_opA, out_opB;
    logic [3:0]  out_rd;
    logic        out_writes_rd, out_is_load;
    logic [15:0] out_ctrl;
    logic [15:0] stall_cnt, bubble_cnt;

    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  rd;
        logic        w;
        logic        l;
        logic [15:0] ctrl;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    operand_fetch_stage dut (
        .clk           (clk),
        .reset         (reset),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_rn         (in_rn),
        .in_rm         (in_rm),
        .in_rd         (in_rd),
        .in_uses_rn    (in_uses_rn),
        .in_uses_rm    (in_uses_rm),
        .in_writes_rd  (in_writes_rd),
        .in_is_load    (in_is_load),
        .in_pc_plus8   (in_pc_plus8),
        .in_ctrl       (in_ctrl),
        .rf_readReg1   (rf_readReg1),
        .rf_readReg2   (rf_readReg2),
        .rf_readData1  (rf_readData1),
        .rf_readData2  (rf_readData2),
        .ex_writes     (ex_writes),
        .ex_is_load    (ex_is_load),
        .ex_rd         (ex_rd),
        .ex_result     (ex_result),
        .wb_writes     (wb_writes),
        .wb_rd         (wb_rd),
        .wb_data       (wb_data),
        .flush         (flush),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_opA       (out_opA),
        .out_opB       (out_opB),
        .out_rd        (out_rd),
        .out_writes_rd (out_writes_rd),
        .out_is_load   (out_is_load),
        .out_ctrl      (out_ctrl),
        .stall_cnt     (stall_cnt),
        .bubble_cnt    (bubble_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference operand resolution from the currently driven bench signals.
    function automatic logic [31:0] model_sel(input logic [3:0] idx, input logic [31:0] rf);
        if (idx == 4'd15) return in_pc_plus8;
        if (ex_writes && !ex_is_load && ex_rd == idx) return ex_result;
        if (wb_writes && wb_rd == idx) return wb_data;
        return rf;
    endfunction

    task automatic idle_inputs();
        in_valid = 0; in_rn = 0; in_rm = 0; in_rd = 0;
        in_uses_rn = 0; in_uses_rm = 0; in_writes_rd = 0; in_is_load = 0;
        in_pc_plus8 = 0; in_ctrl = 0; rf_readData1 = 0; rf_readData2 = 0;
        ex_writes = 0; ex_is_load = 0; ex_rd = 0; ex_result = 0;
        wb_writes = 0; wb_rd = 0; wb_data = 0; flush = 0; out_ready = 1;
    endtask

    task automatic set_instr(input logic [3:0] rn, input logic [3:0] rm, input logic [3:0] rd,
                             input logic [31:0] d1, input logic [31:0] d2, input logic [15:0] ctrl);
        in_valid = 1; in_rn = rn; in_rm = rm; in_rd = rd;
        in_uses_rn = 1; in_uses_rm = 1; in_writes_rd = 1; in_is_load = 0;
        rf_readData1 = d1; rf_readData2 = d2; in_ctrl = ctrl; in_pc_plus8 = 32'h0000_0108;
    endtask

    // One cycle: settle, pop/compare on output handshake, push on input handshake, advance.
    task automatic tick();
        exp_t e;
        #1;
        if (out_valid && out_ready) begin
            checks++;
            assert (sb.size() != 0) else begin
                errors++;
                $error("FAIL sb_underflow observed=%0d expected=nonzero", sb.size());
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("sb_opA", out_opA, e.a);
                chk("sb_opB", out_opB, e.b);
                chk("sb_rd", {28'd0, out_rd}, {28'd0, e.rd});
                chk("sb_flags", {30'd0, out_writes_rd, out_is_load}, {30'd0, e.w, e.l});
                chk("sb_ctrl", {16'd0, out_ctrl}, {16'd0, e.ctrl});
            end
        end
        if (in_valid && in_ready) begin
            e.a = model_sel(in_rn, rf_readData1);
            e.b = model_sel(in_rm, rf_readData2);
            e.rd = in_rd; e.w = in_writes_rd; e.l = in_is_load; e.ctrl = in_ctrl;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
        chk("rst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("rst_bubble_cnt", {16'd0, bubble_cnt}, 32'd0);
        chk("rst_opA", out_opA, 32'd0);
        reset = 0;

        // Plain regfile read
        set_instr(4'd8, 4'd1, 4'd4, 32'hAAAA_AAAA, 32'h5555_5555, 16'h1111);
        #1;
        chk("rf_addr1", {28'd0, rf_readReg1}, 32'd8);
        chk("rf_addr2", {28'd0, rf_readReg2}, 32'd1);
        chk("in_ready_idle", {31'd0, in_ready}, 32'd1);
        tick();
        chk("first_valid", {31'd0, out_valid}, 32'd1);
        chk("first_opA", out_opA, 32'hAAAA_AAAA);

        // EX forward
        set_instr(4'd3, 4'd1, 4'd5, 32'hDEAD_0003, 32'h0000_0001, 16'h2222);
        ex_writes = 1; ex_rd = 4'd3; ex_result = 32'h1234_5678;
        tick();
        chk("ex_fwd_opA", out_opA, 32'h1234_5678);

        // WB forward
        ex_writes = 0; wb_writes = 1; wb_rd = 4'd3; wb_data = 32'hCCCC_CCCC;
        tick();
        chk("wb_fwd_opA", out_opA, 32'hCCCC_CCCC);

        // EX beats WB
        ex_writes = 1;
        tick();
        chk("ex_over_wb_opA", out_opA, 32'h1234_5678);

        // R15 never forwarded
        set_instr(4'd0, 4'd15, 4'd6, 32'h0, 32'hBAD0_BAD0, 16'h3333);
        ex_writes = 1; ex_rd = 4'd15; ex_result = 32'hEEEE_EEEE;
        wb_writes = 1; wb_rd = 4'd15; wb_data = 32'hFFFF_0000;
        tick();
        chk("r15_opB", out_opB, 32'h0000_0108);

        // Load-use hazard
        set_instr(4'd2, 4'd1, 4'd7, 32'h0000_0002, 32'h1, 16'h4444);
        ex_writes = 1; ex_is_load = 1; ex_rd = 4'd2; wb_writes = 0;
        #1;
        chk("hazard_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("bubble_valid", {31'd0, out_valid}, 32'd0);
        chk("bubble_cnt_1", {16'd0, bubble_cnt}, 32'd1);
        ex_writes = 0; ex_is_load = 0;
        wb_writes = 1; wb_rd = 4'd2; wb_data = 32'h0000_0077;
        #1;
        chk("post_bubble_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("post_bubble_opA", out_opA, 32'h0000_0077);

        // Unused source does not stall
        set_instr(4'd2, 4'd9, 4'd8, 32'h2222_0002, 32'h9, 16'h5555);
        in_uses_rn = 0; in_uses_rm = 0;
        ex_writes = 1; ex_is_load = 1; ex_rd = 4'd2; wb_writes = 0;
        #1;
        chk("nouse_in_ready", {31'd0, in_ready}, 32'd1);
        tick();
        chk("nouse_valid", {31'd0, out_valid}, 32'd1);
        chk("nouse_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
        chk("nouse_opA", out_opA, 32'h2222_0002);

        // Backpressure for 3 cycles
        set_instr(4'd6, 4'd1, 4'd9, 32'h6666_6666, 32'h1, 16'h6666);
        ex_writes = 0; ex_is_load = 0; out_ready = 0;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_in_ready", {31'd0, in_ready}, 32'd0);
            tick();
            chk("bp_hold_opA", out_opA, 32'h2222_0002);
            chk("bp_hold_valid", {31'd0, out_valid}, 32'd1);
        end
        chk("bp_stall_cnt", {16'd0, stall_cnt}, 32'd3);
        out_ready = 1;
        tick();
        chk("bp_release_opA", out_opA, 32'h6666_6666);
        idle_inputs();
        tick();
        chk("drained_valid", {31'd0, out_valid}, 32'd0);

        // Flush during a hazard
        set_instr(4'd5, 4'd1, 4'd10, 32'h5, 32'h1, 16'h7777);
        ex_writes = 1; ex_is_load = 1; ex_rd = 4'd5; flush = 1;
        #1;
        chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
        tick();
        chk("flush_valid", {31'd0, out_valid}, 32'd0);
        chk("flush_bubble_cnt", {16'd0, bubble_cnt}, 32'd1);
        ex_writes = 0; ex_is_load = 0;
        tick();
        chk("flush_drop_valid", {31'd0, out_valid}, 32'd0);
        flush = 0;

        // Back-to-back throughput
        for (int i = 0; i < 4; i++) begin
            set_instr(4'($urandom_range(0, 14)), 4'($urandom_range(0, 15)), 4'(i),
                      $urandom, $urandom, 16'($urandom));
            wb_writes = 1'($urandom_range(0, 1)); wb_rd = 4'($urandom_range(0, 15));
            wb_data = $urandom;
            #1;
            chk("tp_in_ready", {31'd0, in_ready}, 32'd1);
            tick();
            chk("tp_valid", {31'd0, out_valid}, 32'd1);
        end
        idle_inputs();
        tick();

        // Reset in the middle of a stall
        set_instr(4'd4, 4'd4, 4'd1, 32'h4444_4444, 32'h4444_4444, 16'h8888);
        tick();
        out_ready = 0;
        tick();
        chk("pre_reset_stall_cnt", {16'd0, stall_cnt}, 32'd4);
        #2;
        reset = 1;
        #1;
        chk("midrst_valid", {31'd0, out_valid}, 32'd0);
        chk("midrst_stall_cnt", {16'd0, stall_cnt}, 32'd0);
        chk("midrst_opA", out_opA, 32'd0);
        sb.delete();
        idle_inputs();
        @(posedge clk); #1;
        reset = 0;
        tick();
        chk("sb_empty", sb.size(), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/operand_fetch_stage.md
Name: operand_fetch_stage

Overview:
- Decode-to-execute boundary stage that sits directly downstream of the 16x32 register file.
- Drives the register file read addresses from the incoming instruction and captures readData1/readData2.
- Resolves read-after-write hazards by forwarding from execute and writeback, substitutes PC+8 for R15 reads, and inserts load-use stall bubbles.
- Presents registered operands to execute through a valid/ready handshake.

Parameters:
- DATA_W, 32, operand and data width.
- REG_AW, 4, register index width (16 architectural registers).
- CTRL_W, 16, opaque decoded control bits passed through unchanged to execute.
- CNT_W, 16, width of the stall and bubble performance counters.

Ports:
- clk  in  1  stage clock.
- reset  in  1  asynchronous, active-high reset.
- in_valid  in  1  decode presents an instruction.
- in_ready  out  1  stage accepts the decode instruction this cycle.
- in_rn, in_rm, in_rd  in  REG_AW  source 1, source 2 and destination register indices.
- in_uses_rn, in_uses_rm  in  1  the corresponding source is actually read.
- in_writes_rd, in_is_load  in  1  instruction writes rd / is a load.
- in_pc_plus8  in  DATA_W  architectural PC value for an R15 read.
- in_ctrl  in  CTRL_W  decoded control bits.
- rf_readReg1, rf_readReg2  out  REG_AW  register file read addresses; combinationally equal to in_rn and in_rm.
- rf_readData1, rf_readData2  in  DATA_W  register file read data (combinational).
- ex_writes, ex_is_load  in  1  the instruction in execute writes rd / is a load.
- ex_rd  in  REG_AW  destination register of the instruction in execute.
- ex_result  in  DATA_W  execute result, valid when ex_is_load=0.
- wb_writes  in  1  register file write enable this cycle.
- wb_rd  in  REG_AW  register file write destination this cycle.
- wb_data  in  DATA_W  register file write data this cycle.
- flush  in  1  branch taken; kill the input and output instructions.
- out_valid  out  1  operands are valid for execute.
- out_ready  in  1  execute accepts the operands.
- out_opA, out_opB  out  DATA_W  resolved operands.
- out_rd  out  REG_AW  destination register, passed through.
- out_writes_rd, out_is_load  out  1  flags, passed through.
- out_ctrl  out  CTRL_W  control bits, passed through.
- stall_cnt, bubble_cnt  out  CNT_W  saturating performance counters.

Behaviour:
- Reset (async, active-high): all out_* = 0, out_valid = 0, both counters = 0, state = RUN.
- Operand select, per source, highest priority first:
  1. idx==15 → in_pc_plus8.
  2. ex_writes && ex_rd==idx && !ex_is_load → ex_result.
  3. wb_writes && wb_rd==idx → wb_data. The register file commits only at the clock edge, so a same-cycle write must be forwarded.
  4. Otherwise the register file read data.
- Register R15 is never forwarded from ex or wb.
- hazard = in_valid && ex_writes && ex_is_load && ((in_uses_rn && ex_rd==in_rn) || (in_uses_rm && ex_rd==in_rm)); a source with uses_*=0 never causes a hazard.
- advance = !out_valid || out_ready.
- in_ready = advance && !hazard && !flush.
- At each posedge, in priority order:
  1. flush: out_valid←0; the input instruction is dropped.
  2. advance && hazard: out_valid←0 (bubble inserted), state←LOAD_STALL, bubble_cnt++.
  3. advance && in_valid: capture operands and passthrough fields, out_valid←1.
  4. advance && !in_valid: out_valid←0.
  5. !advance: hold all out_* registers unchanged; stall_cnt++ if in_valid.
- State machine RUN/LOAD_STALL:
  - LOAD_STALL returns to RUN on the next advance.
  - A second consecutive hazard stays in LOAD_STALL.
  - The state only gates the bubble accounting; the data path is the same in both states.
- Latency is 1 cycle from in_valid&&in_ready to out_valid. Throughput is 1 per cycle with no hazards.
- Outputs are stable while out_valid && !out_ready. Forwarding is evaluated only at capture; held operands are never re-resolved.
- Counters saturate at all ones and never wrap. They clear only on reset.
- Reset asserted mid-stall: out_valid drops immediately and the state returns to RUN.

Decomposition:
- Shared package (cpu_pkg):
  - Register index constants REG_PC=15, REG_LR=14, REG_SP=13.
  - DATA_W and REG_AW defaults.
  - Stage state encoding RUN=0, LOAD_STALL=1.
- Sub-module operand_forward_mux: a single combinational source resolver, instantiated twice (rn, rm).

Test Plan:
- Reset: hold reset 2 cycles → out_valid=0, stall_cnt=0, bubble_cnt=0; set rf_readData1=32'hAAAAAAAA, in_rn=8, in_valid=1 → next cycle out_opA=32'hAAAAAAAA, out_valid=1.
- EX forward: ex_writes=1, ex_rd=3, ex_result=32'h12345678, in_rn=3 → out_opA=32'h12345678. Repeat with wb_writes=1, wb_rd=3, wb_data=32'hCCCCCCCC and ex_writes=0 → out_opA=32'hCCCCCCCC; with both asserted, EX wins.
- R15: in_rm=15, in_pc_plus8=32'h00000108, ex_writes=1, ex_rd=15 → out_opB=32'h00000108.
- Load-use: ex_is_load=1, ex_writes=1, ex_rd=2, in_rn=2, in_uses_rn=1 → in_ready=0, one cycle with out_valid=0, bubble_cnt=1. With in_uses_rn=0 → no stall.
- Backpressure: out_ready=0 for 3 cycles with in_valid=1 → out_* held, in_ready=0, stall_cnt=3. Then out_ready=1 → the next instruction is captured.
- Flush during a stall: hazard present plus flush=1 → out_valid=0 next cycle, in_ready=0, input dropped, bubble_cnt unchanged.
